// File: rtl/fp_div_seq.sv
// fp_div_seq
// Sequential IEEE-754 single-precision divider, OUT = A / B.
// A restoring radix-2 mantissa divider produces one quotient bit per clock.
// Denormal inputs and outputs are supported. Results truncate toward zero.
// NaN, +/-INF and +/-0 are resolved in one cycle without iterating.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while idle; A and B are captured on that edge
//   A, B   - dividend and divisor, IEEE-754 single
//   busy   - high from the capture edge until the edge that raises done
//   done   - one-cycle pulse; OUT is valid from this cycle on
//   OUT    - quotient, held until the next result is written
module fp_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] OUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DIV  = 2'd2,
        POST = 2'd3
    } state_t;

    // Leading-zero count of a 24-bit value (24 when the value is zero).
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd0;
        hit = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!hit && !v[i]) begin
                n = n + 5'd1;
            end else begin
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    state_t             state_q, state_d;
    logic        [31:0] a_q, a_d;
    logic        [31:0] b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic        [31:0] out_q, out_d;
    logic               so_q, so_d;
    logic signed [9:0]  exp_q, exp_d;
    logic        [24:0] rem_q, rem_d;
    logic        [23:0] div_q, div_d;
    logic        [24:0] quo_q, quo_d;
    logic        [4:0]  cnt_q, cnt_d;

    // Operand classification and normalization (used in PRE)
    logic               so_s;
    logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic        [4:0]  lzc_a_s, lzc_b_s;
    logic        [23:0] ma_s, mb_s;
    logic signed [9:0]  ea_s, eb_s;
    // Iteration step (used in DIV)
    logic               ge_s;
    logic        [24:0] rem_sub_s;
    // Normalization and packing of the result (used in POST)
    logic        [23:0] m_s;
    logic signed [9:0]  e_post_s;
    logic signed [9:0]  sh_s;
    logic        [22:0] mant_sh_s;

    // Next-state, datapath and output computation
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        so_d    = so_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;

        so_s     = a_q[31] ^ b_q[31];
        a_nan_s  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
        b_nan_s  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);
        a_inf_s  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
        b_inf_s  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
        a_zero_s = (a_q[30:0] == 31'h0);
        b_zero_s = (b_q[30:0] == 31'h0);
        lzc_a_s  = lzc24({1'b0, a_q[22:0]});
        lzc_b_s  = lzc24({1'b0, b_q[22:0]});

        // Denormals are shifted up so the mantissa MSB is always set;
        // the shift is paid back through the effective exponent.
        if (a_q[30:23] == 8'h00) begin
            ma_s = {1'b0, a_q[22:0]} << lzc_a_s;
            ea_s = 10'sd1 - $signed({5'd0, lzc_a_s});
        end else begin
            ma_s = {1'b1, a_q[22:0]};
            ea_s = $signed({2'b00, a_q[30:23]});
        end
        if (b_q[30:23] == 8'h00) begin
            mb_s = {1'b0, b_q[22:0]} << lzc_b_s;
            eb_s = 10'sd1 - $signed({5'd0, lzc_b_s});
        end else begin
            mb_s = {1'b1, b_q[22:0]};
            eb_s = $signed({2'b00, b_q[30:23]});
        end

        ge_s = (rem_q >= {1'b0, div_q});
        if (ge_s) begin
            rem_sub_s = rem_q - {1'b0, div_q};
        end else begin
            rem_sub_s = rem_q;
        end

        // Both mantissas lie in [1,2), so the quotient lies in (1/2,2):
        // either the integer bit or the next bit is set.
        if (quo_q[24]) begin
            m_s      = quo_q[24:1];
            e_post_s = exp_q;
        end else begin
            m_s      = quo_q[23:0];
            e_post_s = exp_q - 10'sd1;
        end
        sh_s      = 10'sd1 - e_post_s;
        mant_sh_s = 23'(m_s >> sh_s[4:0]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    busy_d  = 1'b1;
                    state_d = PRE;
                end else begin
                    state_d = IDLE;
                end
            end
            PRE: begin
                so_d = so_s;
                if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
                    out_d   = {so_s, 8'hFF, 23'h7FFFFF};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (a_inf_s || b_zero_s) begin
                    out_d   = {so_s, 8'hFF, 23'h000000};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (a_zero_s || b_inf_s) begin
                    out_d   = {so_s, 8'h00, 23'h000000};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    exp_d   = ea_s - eb_s + 10'sd127;
                    rem_d   = {1'b0, ma_s};
                    div_d   = mb_s;
                    quo_d   = 25'd0;
                    cnt_d   = 5'd24;
                    state_d = DIV;
                end
            end
            DIV: begin
                quo_d = {quo_q[23:0], ge_s};
                rem_d = rem_sub_s << 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = POST;
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                    state_d = DIV;
                end
            end
            POST: begin
                if (e_post_s >= 10'sd255) begin
                    out_d = {so_q, 8'hFF, 23'h000000};
                end else if (e_post_s >= 10'sd1) begin
                    out_d = {so_q, e_post_s[7:0], m_s[22:0]};
                end else if (sh_s >= 10'sd24) begin
                    out_d = {so_q, 8'h00, 23'h000000};
                end else begin
                    out_d = {so_q, 8'h00, mant_sh_s};
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= 32'h0;
            so_q    <= 1'b0;
            exp_q   <= 10'sd0;
            rem_q   <= 25'd0;
            div_q   <= 24'd0;
            quo_q   <= 25'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            so_q    <= so_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign OUT  = out_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Testbench for fp_div_seq: directed vectors with hand-computed quotients.
// Stimulus pushes the expected result and completion edge into a queue;
// an independent monitor pops and compares whenever done is seen.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] OUT;

    typedef struct {
        logic [31:0] out;
        int          edge_n;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    logic [31:0] held = 32'h0;

    localparam int NV = 13;
    logic [31:0] tab_a [NV] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                                32'hC0A00000, 32'h7FC00000, 32'h00000001, 32'h00800000,
                                32'h00800000, 32'h7F000000, 32'hC1200000, 32'h7F800000,
                                32'h7F800000};
    logic [31:0] tab_b [NV] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                                32'h7F800000, 32'h3F800000, 32'h3F000000, 32'h4B000000,
                                32'h4B800000, 32'h3F000000, 32'h40A00000, 32'hFF800000,
                                32'h40000000};
    logic [31:0] tab_o [NV] = '{32'h40400000, 32'h3EAAAAAA, 32'h7F800000, 32'h7FFFFFFF,
                                32'h80000000, 32'h7FFFFFFF, 32'h00000002, 32'h00000001,
                                32'h00000000, 32'h7F800000, 32'hC0000000, 32'hFFFFFFFF,
                                32'h7F800000};
    int          tab_l [NV] = '{27, 27, 1, 1, 1, 1, 27, 27, 27, 27, 27, 1, 1};

    fp_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .OUT   (OUT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: result and latency on done, hold of OUT otherwise
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = 32'h0;
        end else if (done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: OUT=%h with no request pending", OUT);
            end else begin
                e = sb_q.pop_front();
                if (OUT !== e.out) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", OUT, e.out);
                end
                checks++;
                if (edge_cnt != e.edge_n) begin
                    errors++;
                    $display("FAIL latency: done after edge %0d expected edge %0d", edge_cnt, e.edge_n);
                end
                held = e.out;
            end
        end else begin
            checks++;
            if (OUT !== held) begin
                errors++;
                $display("FAIL hold: OUT=%h expected %h", OUT, held);
            end
        end
    end

    // Drive a request at the current negedge and queue its expectation
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_out, input int lat);
        exp_t e;
        A     = a;
        B     = b;
        start = 1'b1;
        e.out    = exp_out;
        e.edge_n = edge_cnt + 1 + lat;
        sb_q.push_back(e);
    endtask

    // Wait for done, scrambling inputs after capture; optional start glitch
    task automatic wait_done(input int lat, input int glitch);
        int nbusy = 0;
        bit seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                A     = $urandom;
                B     = $urandom;
            end
            if (i == glitch) begin
                start = 1'b1;
                A     = 32'h3F800000;
                B     = 32'h3F800000;
            end
            if (i == glitch + 1) start = 1'b0;
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout: no done within 40 cycles");
        end
        checks++;
        if (nbusy != lat) begin
            errors++;
            $display("FAIL busy_cycles: got %0d expected %0d", nbusy, lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done: got %b expected 0", busy);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (OUT !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 00000000", OUT); end
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            issue(tab_a[i], tab_b[i], tab_o[i], tab_l[i]);
            wait_done(tab_l[i], -10);
        end

        // start pulsed mid-DIV must be ignored
        @(negedge clk);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 27);
        wait_done(27, 5);

        // back-to-back: start in the done cycle, then into a special
        @(negedge clk);
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27);
        wait_done(27, -10);
        issue(32'h40000000, 32'h3F800000, 32'h40000000, 27);
        wait_done(27, -10);
        issue(32'h3F800000, 32'h00000000, 32'h7F800000, 1);
        wait_done(1, -10);
        repeat (35) @(negedge clk);

        // reset in flight: discarded, no done, then a clean operation
        @(negedge clk);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 27);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++;
        if (OUT !== 32'h0) begin errors++; $display("FAIL rst_out: got %h expected 00000000", OUT); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);

        @(negedge clk);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 27);
        wait_done(27, -10);
        repeat (3) @(negedge clk);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never arrived, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
